bcd_lap_counter: RTL
====================

BCD_LAP_COUNTER -- requirements
Module: bcd_lap_counter

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 4: number of BCD digits, legal range 2..8.
REQ-002 The block SHALL have parameter TICK_DIV, default 1: stopwatch_clock cycles per count tick, legal range 1..2^24.
REQ-003 The block SHALL have port stopwatch_clock  input  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port start_stop_toggle  input  1  level run enable: 1 = run, 0 = hold.
REQ-006 The block SHALL have port reset_toggle  input  1  synchronous clear/reload strobe.
REQ-007 The block SHALL have port mode_sel  input  2  mode encoding: 00 up from 0, 01 up from preset, 10 down from all-9s, 11 down from preset.
REQ-008 The block SHALL have port init_val  input  4*NUM_DIGITS  BCD preset, digit 0 in bits [3:0].
REQ-009 The block SHALL have port lap_toggle  input  1  one-cycle pulse that freezes or releases the display.
REQ-010 The block SHALL have port digits  output  4*NUM_DIGITS  displayed BCD value.
REQ-011 The block SHALL have ports running, lap_active, done  output  1 each  status flags.

Function
REQ-012 The block SHALL implement an FSM with states IDLE, RUN, PAUSE and DONE; running SHALL be 1 only in RUN.
REQ-013 reset_toggle=1 SHALL have top priority and, on the next edge, SHALL:
- latch mode_sel;
- load count with the start value: 0 / preset / all-9s / preset;
- enter IDLE;
- clear lap_active, done and the prescaler.
REQ-014 mode_sel SHALL be sampled only on reset_toggle; changes at other times SHALL be ignored.
REQ-015 A preset nibble greater than 9 SHALL be loaded as 9.
REQ-016 FSM transitions SHALL be:
- IDLE->RUN and PAUSE->RUN when start_stop_toggle=1;
- RUN->PAUSE when start_stop_toggle=0;
- RUN->DONE per REQ-020;
- DONE SHALL exit only on reset_toggle.
REQ-017 The prescaler SHALL count 0..TICK_DIV-1 only in RUN, SHALL hold in other states, and SHALL issue one tick on its terminal count.
REQ-018 With TICK_DIV=1, a tick SHALL occur on every RUN cycle.
REQ-019 On a tick, count SHALL update as a BCD ripple:
- up: digit i increments (9->0) only when all lower digits are 9;
- down: digit i decrements (0->9) only when all lower digits are 0.
REQ-020 The terminal value SHALL be all-9s for up modes and all-0s for down modes.
REQ-021 A tick that produces the terminal value SHALL move the FSM to DONE and set done=1 on that same edge.
REQ-022 The count SHALL saturate and never wrap.
REQ-023 If count already equals the terminal value on entry to RUN, the first tick SHALL leave count unchanged and enter DONE.
REQ-024 lap_toggle in RUN or PAUSE SHALL act as follows:
- if lap_active=0: capture count into the lap register and set lap_active=1;
- else: clear lap_active.
REQ-025 lap_toggle SHALL be ignored in IDLE.
REQ-026 In DONE, lap_toggle SHALL only be able to clear lap_active.
REQ-027 digits SHALL equal the lap register while lap_active=1, and the live count register otherwise, with no added cycle of latency.
REQ-028 Counting SHALL continue unaffected while lap_active=1.
REQ-029 When reset_toggle and lap_toggle are asserted in the same cycle, reset_toggle SHALL win.
REQ-030 A tick and a lap capture in the same cycle SHALL capture the pre-tick count.

Reset
REQ-031 reset_n=0 SHALL immediately force:
- FSM to IDLE;
- count, lap register and prescaler to 0;
- latched mode to 00;
- digits to 0;
- running, lap_active and done to 0.
REQ-032 Deassertion of reset_n SHALL be synchronised by the integrating top level; no state SHALL change until the first edge after deassertion.
REQ-033 reset_n assertion mid-count SHALL discard all progress, including a frozen lap value.

Structure
REQ-034 A shared package bcd_counter_pkg SHALL hold:
- the FSM state enum;
- the mode_sel encoding constants;
- the BCD digit width constant (4).
REQ-035 One sub-module, bcd_digit_cell, SHALL implement a single digit with load, inc/dec, carry-in/borrow-in and carry-out/borrow-out.
REQ-036 NUM_DIGITS instances of bcd_digit_cell SHALL be generated in a chain.
REQ-037 The prescaler width SHALL be derived from TICK_DIV; no literals SHALL depend on NUM_DIGITS.

Verification
REQ-038 The bench SHALL cover the following scenarios, all with NUM_DIGITS=4 and TICK_DIV=1:
- mode 00, reset_toggle then run 1234 cycles -> digits=1234; continue to 9999 -> done=1, digits held at 9999 for 10 further cycles.
- mode 11, init_val=0x0103, run 103 ticks -> digits=0000 and done=1 on the 103rd tick edge; start_stop_toggle=0 mid-way for 20 cycles -> count frozen.
- mode 01, init_val=0x0A99 -> loaded 0999; 1 tick -> 1000 (triple carry).
- lap_toggle at count 0042 -> digits hold 0042 while live count reaches 0060; second lap_toggle -> digits=0060 on the same edge.
- reset_n pulsed low mid-run at count 0500 with lap_active=1 -> all outputs 0 asynchronously, FSM IDLE.
- reset_toggle and lap_toggle in the same cycle in RUN -> reload wins, lap_active=0.
- TICK_DIV=5 variant: 50 RUN cycles -> digits=0010.

Source files
------------

// File: rtl/bcd_counter_pkg.sv
// Shared types and constants for the BCD lap counter.
package bcd_counter_pkg;

   // Width of one BCD digit
   localparam int unsigned DigitW = 4;

   // Largest legal BCD digit value
   localparam logic [DigitW-1:0] BcdNine = DigitW'(9);

   // mode_sel encodings
   localparam logic [1:0] ModeUpZero     = 2'b00;
   localparam logic [1:0] ModeUpPreset   = 2'b01;
   localparam logic [1:0] ModeDownNines  = 2'b10;
   localparam logic [1:0] ModeDownPreset = 2'b11;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StPause,
      StDone
   } state_e;

   // Out-of-range preset nibbles load as 9
   function automatic logic [DigitW-1:0] clamp_bcd(input logic [DigitW-1:0] nib);
      return (nib > BcdNine) ? BcdNine : nib;
   endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit: loadable, steps up or down when its carry/borrow-in is set.
module bcd_digit_cell
   import bcd_counter_pkg::*;
(
   input  logic              stopwatch_clock,
   input  logic              reset_n,
   input  logic              load,
   input  logic [DigitW-1:0] load_val,
   input  logic              step,
   input  logic              down,
   input  logic              cin,
   output logic [DigitW-1:0] value,
   output logic [DigitW-1:0] nxt,
   output logic              cout
);

   logic [DigitW-1:0] value_q;
   logic              at_edge;

   // Carry/borrow-out and the value this digit would hold after a step
   always_comb begin
      at_edge = down ? (value_q == '0) : (value_q == BcdNine);
      cout    = cin & at_edge;
      nxt     = value_q;
      if (cin) begin
         if (down) begin
            nxt = at_edge ? BcdNine : value_q - DigitW'(1);
         end else begin
            nxt = at_edge ? '0 : value_q + DigitW'(1);
         end
      end
   end

   // Digit register: load has priority over stepping
   always_ff @(posedge stopwatch_clock or negedge reset_n) begin
      if (!reset_n) begin
         value_q <= '0;
      end else if (load) begin
         value_q <= load_val;
      end else if (step) begin
         value_q <= nxt;
      end
   end

   assign value = value_q;

endmodule

// File: rtl/bcd_lap_counter.sv
// Up/down BCD stopwatch with prescaler, saturating terminal detect and lap freeze.
module bcd_lap_counter
   import bcd_counter_pkg::*;
#(
   parameter int unsigned NUM_DIGITS = 4,
   parameter int unsigned TICK_DIV   = 1
) (
   input  logic                         stopwatch_clock,
   input  logic                         reset_n,
   input  logic                         start_stop_toggle,
   input  logic                         reset_toggle,
   input  logic [1:0]                   mode_sel,
   input  logic [DigitW*NUM_DIGITS-1:0] init_val,
   input  logic                         lap_toggle,
   output logic [DigitW*NUM_DIGITS-1:0] digits,
   output logic                         running,
   output logic                         lap_active,
   output logic                         done
);

   localparam int unsigned CountW = DigitW * NUM_DIGITS;
   localparam int unsigned PreW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PreW-1:0] PreLast = PreW'(TICK_DIV - 1);

   state_e            state_q;
   logic [1:0]        mode_q;
   logic [PreW-1:0]   pre_q;
   logic [CountW-1:0] lap_q;
   logic              lap_active_q;
   logic              done_q;
   logic              running_q;

   logic [CountW-1:0] count;
   logic [CountW-1:0] count_nxt;
   logic [CountW-1:0] terminal;
   logic [NUM_DIGITS:0] carry;
   logic              down;
   logic              tick;
   logic              at_term;
   logic              reach_term;
   logic              step;

   // Tick, direction and terminal-value detection
   always_comb begin
      down       = (mode_q == ModeDownNines) || (mode_q == ModeDownPreset);
      tick       = (state_q == StRun) && (pre_q == PreLast);
      at_term    = carry[NUM_DIGITS];
      terminal   = down ? '0 : {NUM_DIGITS{BcdNine}};
      // Already at terminal: the tick leaves count alone but still finishes
      reach_term = tick && (at_term || (count_nxt == terminal));
      step       = tick && !at_term;
   end

   assign carry[0] = 1'b1;

   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
      logic [DigitW-1:0] ld_val;

      // Start value for this digit, chosen by the incoming mode_sel
      always_comb begin
         case (mode_sel)
            ModeUpZero:    ld_val = '0;
            ModeDownNines: ld_val = BcdNine;
            default:       ld_val = clamp_bcd(init_val[i*DigitW +: DigitW]);
         endcase
      end

      bcd_digit_cell u_cell (
         .stopwatch_clock (stopwatch_clock),
         .reset_n         (reset_n),
         .load            (reset_toggle),
         .load_val        (ld_val),
         .step            (step),
         .down            (down),
         .cin             (carry[i]),
         .value           (count[i*DigitW +: DigitW]),
         .nxt             (count_nxt[i*DigitW +: DigitW]),
         .cout            (carry[i+1])
      );
   end

   // Control FSM, prescaler, lap register and status flags
   always_ff @(posedge stopwatch_clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= StIdle;
         mode_q       <= ModeUpZero;
         pre_q        <= '0;
         lap_q        <= '0;
         lap_active_q <= 1'b0;
         done_q       <= 1'b0;
         running_q    <= 1'b0;
      end else if (reset_toggle) begin
         state_q      <= StIdle;
         mode_q       <= mode_sel;
         pre_q        <= '0;
         lap_active_q <= 1'b0;
         done_q       <= 1'b0;
         running_q    <= 1'b0;
      end else begin
         if (state_q == StRun) begin
            pre_q <= (pre_q == PreLast) ? '0 : pre_q + PreW'(1);
         end

         // Lap captures the pre-tick count; in DONE it may only release
         if (lap_toggle) begin
            case (state_q)
               StRun, StPause: begin
                  if (!lap_active_q) begin
                     lap_q        <= count;
                     lap_active_q <= 1'b1;
                  end else begin
                     lap_active_q <= 1'b0;
                  end
               end
               StDone:  lap_active_q <= 1'b0;
               default: ;
            endcase
         end

         case (state_q)
            StIdle, StPause: begin
               if (start_stop_toggle) begin
                  state_q   <= StRun;
                  running_q <= 1'b1;
               end
            end
            StRun: begin
               if (reach_term) begin
                  state_q   <= StDone;
                  done_q    <= 1'b1;
                  running_q <= 1'b0;
               end else if (!start_stop_toggle) begin
                  state_q   <= StPause;
                  running_q <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign digits     = lap_active_q ? lap_q : count;
   assign running    = running_q;
   assign lap_active = lap_active_q;
   assign done       = done_q;

endmodule
